// File: rtl/phv_action_aligner.sv
// rtl/phv_action_aligner.sv - pairs buffered PHVs with in-order lookup actions (optional stats: PHV_ALIGN_STATS_EN)
module phv_action_aligner #(
    parameter int STAGE   = 0,
    parameter int PHV_LEN = 1124,
    parameter int ACT_LEN = 25,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PHV_LEN-1:0]     phv_in,
    input  logic                   phv_valid_in,
    input  logic [ACT_LEN*25-1:0]  action_in,
    input  logic                   action_valid_in,
    output logic [PHV_LEN-1:0]     phv_out,
    output logic                   phv_valid_out,
    output logic [ACT_LEN*25-1:0]  action_out,
    output logic                   action_valid_out,
    output logic                   overflow_err,
    output logic                   orphan_err
`ifdef PHV_ALIGN_STATS_EN
    ,
    output logic [15:0]            pair_cnt,
    output logic [15:0]            drop_phv_cnt,
    output logic [15:0]            drop_act_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    // Pointers rely on DEPTH being a power of two so they wrap for free.
    if (STAGE < 0 || DEPTH < 2 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("phv_action_aligner: STAGE must be >= 0 and DEPTH a power of two in 2..32");
    end

    logic [PHV_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        occ;

    logic pop_ok;
    logic orphan;
    logic push_ok;
    logic overflow;

    // Pop/push qualification; occupancy is the registered value, so a PHV
    // written this cycle can never satisfy an action in the same cycle.
    always_comb begin
        pop_ok   = action_valid_in && (occ != '0);
        orphan   = action_valid_in && (occ == '0);
        push_ok  = phv_valid_in && ((occ != OCC_FULL) || pop_ok);
        overflow = phv_valid_in && !push_ok;
    end

    // PHV storage; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr] <= phv_in;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Output register: one-cycle valid pulse per pair, data held otherwise.
    // When full with a simultaneous push, wr_ptr equals rd_ptr and the read
    // still returns the old head because the write lands after this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phv_out          <= '0;
            action_out       <= '0;
            phv_valid_out    <= 1'b0;
            action_valid_out <= 1'b0;
        end else begin
            phv_valid_out    <= pop_ok;
            action_valid_out <= pop_ok;
            if (pop_ok) begin
                phv_out    <= mem[rd_ptr];
                action_out <= action_in;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
            orphan_err   <= 1'b0;
        end else begin
            if (overflow) begin
                overflow_err <= 1'b1;
            end
            if (orphan) begin
                orphan_err <= 1'b1;
            end
        end
    end

`ifdef PHV_ALIGN_STATS_EN
    // Saturating event counters for pairs, dropped PHVs and orphan actions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_cnt     <= '0;
            drop_phv_cnt <= '0;
            drop_act_cnt <= '0;
        end else begin
            if (pop_ok && pair_cnt != 16'hFFFF) begin
                pair_cnt <= pair_cnt + 16'd1;
            end
            if (overflow && drop_phv_cnt != 16'hFFFF) begin
                drop_phv_cnt <= drop_phv_cnt + 16'd1;
            end
            if (orphan && drop_act_cnt != 16'hFFFF) begin
                drop_act_cnt <= drop_act_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_phv_action_aligner.sv
// tb/tb_phv_action_aligner.sv - directed table-driven bench for phv_action_aligner
`timescale 1ns/1ps
module tb_phv_action_aligner;

    localparam int PW = 32;
    localparam int AL = 8;
    localparam int AW = AL * 25;
    localparam int D  = 8;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] phv_in;
    logic          phv_valid_in;
    logic [AW-1:0] action_in;
    logic          action_valid_in;
    logic [PW-1:0] phv_out;
    logic          phv_valid_out;
    logic [AW-1:0] action_out;
    logic          action_valid_out;
    logic          overflow_err;
    logic          orphan_err;
`ifdef PHV_ALIGN_STATS_EN
    logic [15:0]   pair_cnt;
    logic [15:0]   drop_phv_cnt;
    logic [15:0]   drop_act_cnt;
`endif

    phv_action_aligner #(
        .STAGE   (3),
        .PHV_LEN (PW),
        .ACT_LEN (AL),
        .DEPTH   (D)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phv_in           (phv_in),
        .phv_valid_in     (phv_valid_in),
        .action_in        (action_in),
        .action_valid_in  (action_valid_in),
        .phv_out          (phv_out),
        .phv_valid_out    (phv_valid_out),
        .action_out       (action_out),
        .action_valid_out (action_valid_out),
        .overflow_err     (overflow_err),
        .orphan_err       (orphan_err)
`ifdef PHV_ALIGN_STATS_EN
        ,
        .pair_cnt         (pair_cnt),
        .drop_phv_cnt     (drop_phv_cnt),
        .drop_act_cnt     (drop_act_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          pv;
        logic [PW-1:0] phv;
        logic          av;
        logic [AW-1:0] act;
        logic          ev;
        logic [PW-1:0] ephv;
        logic [AW-1:0] eact;
        logic [3:0]    eocc;
        logic          eovf;
        logic          eorph;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [AW-1:0] mk(input logic [7:0] b);
        return {25{b}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic pv, input logic [PW-1:0] p,
                        input logic av, input logic [AW-1:0] a);
        rst_n           = r;
        phv_valid_in    = pv;
        phv_in          = p;
        action_valid_in = av;
        action_in       = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [PW-1:0] ep,
                           input logic [AW-1:0] ea, input logic [3:0] eo,
                           input logic eovf, input logic eorph);
        chk({tag, ".phv_valid"}, 256'(phv_valid_out), 256'(ev));
        chk({tag, ".act_valid"}, 256'(action_valid_out), 256'(ev));
        chk({tag, ".phv_out"},   256'(phv_out), 256'(ep));
        chk({tag, ".act_out"},   256'(action_out), 256'(ea));
        chk({tag, ".occ"},       256'(dut.occ), 256'(eo));
        chk({tag, ".ovf"},       256'(overflow_err), 256'(eovf));
        chk({tag, ".orph"},      256'(orphan_err), 256'(eorph));
    endtask

    initial begin
        logic [PW-1:0] pa, pb, pc, pd;
        pa = 32'hAAAA0001; pb = 32'hBBBB0002; pc = 32'hCCCC0003; pd = 32'hDDDD0004;

        rst_n = 1'b0; phv_valid_in = 1'b0; phv_in = '0;
        action_valid_in = 1'b0; action_in = '0;
        @(negedge clk);

        // rst pv phv av act | ev ephv eact occ ovf orph
        tbl.push_back('{1'b0, 1'b0, '0, 1'b0, '0,          1'b0, '0, '0,          4'd0, 1'b0, 1'b0});
        // A,B,C then X,Y,Z: outputs one cycle after each action
        tbl.push_back('{1'b1, 1'b1, pa, 1'b0, '0,          1'b0, '0, '0,          4'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, pb, 1'b0, '0,          1'b0, '0, '0,          4'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, pc, 1'b0, '0,          1'b0, '0, '0,          4'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, mk(8'h58),   1'b1, pa, mk(8'h58),   4'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, mk(8'h59),   1'b1, pb, mk(8'h59),   4'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, mk(8'h5A),   1'b1, pc, mk(8'h5A),   4'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, '0, 1'b0, mk(8'h11),   1'b0, pc, mk(8'h5A),   4'd0, 1'b0, 1'b0});
        // orphan alone, then orphan with same-cycle push
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, mk(8'h21),   1'b0, pc, mk(8'h5A),   4'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, pd, 1'b1, mk(8'h22),   1'b0, pc, mk(8'h5A),   4'd1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, mk(8'h23),   1'b1, pd, mk(8'h23),   4'd0, 1'b0, 1'b1});
        // reset clears flags; buffer 5, reset with valid inputs, then action
        tbl.push_back('{1'b0, 1'b0, '0, 1'b0, '0,          1'b0, '0, '0,          4'd0, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{1'b1, 1'b1, 32'h5000 + i, 1'b0, '0, 1'b0, '0, '0, 4'(i + 1), 1'b0, 1'b0});
        end
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, mk(8'h31),   1'b1, 32'h5000, mk(8'h31), 4'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, pa, 1'b1, mk(8'h32),   1'b0, '0, '0,          4'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, '0, 1'b1, mk(8'h33),   1'b0, '0, '0,          4'd0, 1'b0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].pv, tbl[i].phv, tbl[i].av, tbl[i].act);
            chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ephv, tbl[i].eact,
                    tbl[i].eocc, tbl[i].eovf, tbl[i].eorph);
        end

        // Overflow: nine back-to-back pushes, ninth dropped, then in-order drain
        step(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 32'(100 + i), 1'b0, '0);
            chk($sformatf("ovf_push%0d.occ", i), 256'(dut.occ), 256'((i < 8) ? i + 1 : 8));
            chk($sformatf("ovf_push%0d.ovf", i), 256'(overflow_err), 256'(i == 8));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, mk(8'(8'h40 + i)));
            chk_all($sformatf("ovf_pop%0d", i), 1'b1, 32'(100 + i), mk(8'(8'h40 + i)),
                    4'(7 - i), 1'b1, 1'b0);
        end

        // Full buffer with simultaneous push and pop
        step(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'(200 + i), 1'b0, '0);
        step(1'b1, 1'b1, 32'd208, 1'b1, mk(8'h77));
        chk_all("full_pp", 1'b1, 32'd200, mk(8'h77), 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, mk(8'(8'h60 + i)));
            chk_all($sformatf("full_pop%0d", i), 1'b1, 32'(201 + i), mk(8'(8'h60 + i)),
                    4'(7 - i), 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, '0, 1'b0, '0);
        chk_all("full_idle", 1'b0, 32'd208, mk(8'h67), 4'd0, 1'b0, 1'b0);

`ifdef PHV_ALIGN_STATS_EN
        step(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 32'(i), 1'b0, '0);
            step(1'b1, 1'b0, '0, 1'b1, mk(8'(i)));
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, '0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'(i), 1'b0, '0);
        chk("stats.pair", 256'(pair_cnt), 256'(20));
        chk("stats.drop_phv", 256'(drop_phv_cnt), 256'(2));
        chk("stats.drop_act", 256'(drop_act_cnt), 256'(3));
        force dut.pair_cnt = 16'hFFFF;
        step(1'b1, 1'b0, '0, 1'b0, '0);
        release dut.pair_cnt;
        step(1'b1, 1'b0, '0, 1'b1, mk(8'h99));
        chk("stats.sat", 256'(pair_cnt), 256'(16'hFFFF));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phv_action_aligner.md
PHV_ACTION_ALIGNER -- requirements
Module: phv_action_aligner

Interface
REQ-001 Parameter STAGE, default 0: stage index; no functional effect beyond identification.
REQ-002 Parameter PHV_LEN, default 1124: PHV width in bits.
REQ-003 Parameter ACT_LEN, default 25: width of one sub-action; the action bus is ACT_LEN*25 bits.
REQ-004 Parameter DEPTH, default 8: PHV buffer entries; power of 2, range 2..32.
REQ-005 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 Port phv_in, input, PHV_LEN: PHV arriving from the key-extract/parser side.
REQ-008 Port phv_valid_in, input, 1: phv_in is valid this cycle.
REQ-009 Port action_in, input, ACT_LEN*25: action word returned by the lookup engine.
REQ-010 Port action_valid_in, input, 1: action_in is valid this cycle.
REQ-011 Port phv_out, output, PHV_LEN: aligned PHV, drives the action engine phv_in.
REQ-012 Port phv_valid_out, output, 1: aligned PHV valid.
REQ-013 Port action_out, output, ACT_LEN*25: aligned action, drives the action engine action_in.
REQ-014 Port action_valid_out, output, 1: aligned action valid; always equal to phv_valid_out.
REQ-015 Port overflow_err, output, 1: sticky flag; a PHV was dropped because the buffer was full.
REQ-016 Port orphan_err, output, 1: sticky flag; an action arrived while no PHV was buffered.

Function
REQ-017 Accepted PHVs shall be written into a DEPTH-entry in-order FIFO, each entry PHV_LEN bits wide.
REQ-018 Each action_valid_in pulse shall pop the oldest buffered PHV and pair it with action_in; actions match PHVs strictly in arrival order.
REQ-019 A paired PHV and action shall be registered to phv_out/action_out with phv_valid_out=action_valid_out=1 on the cycle after action_valid_in (latency 1).
REQ-020 Outputs shall be 1-cycle pulses per pair; the block applies no backpressure and has no ready input.
REQ-021 On cycles with no pair, valids shall be 0 and data outputs shall hold their last value.
REQ-022 The occupancy counter shall be log2(DEPTH)+1 bits wide; read and write pointers shall be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 A write shall not be visible to a read in the same cycle, so the minimum lookup latency is 1 cycle.
REQ-024 When an action arrives with occupancy 0, including when a PHV is written that same cycle, the action shall be discarded, orphan_err shall be set, and no output shall be produced.
REQ-025 A PHV arriving at occupancy DEPTH with no pop that cycle shall be discarded and shall set overflow_err.
REQ-026 A PHV arriving at occupancy DEPTH with a simultaneous pop shall be accepted; occupancy stays at DEPTH.
REQ-027 A simultaneous accepted push and valid pop shall leave occupancy unchanged.
REQ-028 overflow_err and orphan_err shall clear only on reset.

Reset
REQ-029 When rst_n=0 at a clock edge: pointers=0, occupancy=0, phv_valid_out=0, action_valid_out=0, phv_out=0, action_out=0, overflow_err=0, orphan_err=0, and counters (if present)=0.
REQ-030 Reset asserted mid-operation shall discard all buffered PHVs; valid inputs in the reset cycle shall be ignored.
REQ-031 FIFO storage contents need not be reset.

Configuration
REQ-032 With macro PHV_ALIGN_STATS_EN defined, the block shall add outputs pair_cnt, drop_phv_cnt and drop_act_cnt, each 16 bits: aligned pairs, overflow drops and orphan actions; each counter saturates at 0xFFFF.
REQ-033 With PHV_ALIGN_STATS_EN undefined, those ports and counters shall be absent; all other behaviour is identical.

Verification
REQ-034 Push PHVs A,B,C on cycles 0,1,2; actions X,Y,Z on cycles 3,4,5 -> outputs A/X, B/Y, C/Z on cycles 4,5,6 with both valids high; no errors.
REQ-035 With DEPTH=8, push 9 PHVs back-to-back with no actions -> 9th dropped, overflow_err=1 from cycle 9; 8 subsequent actions return PHVs 1..8 in order.
REQ-036 Buffer full (8 entries); push PHV and action in the same cycle -> PHV accepted, head popped, occupancy stays 8, no error.
REQ-037 Empty buffer; action_valid_in alone, then PHV and action in the same cycle -> no outputs, orphan_err=1, occupancy=1 afterwards.
REQ-038 Buffer 5 entries, rst_n=0 for 1 cycle, then action -> orphan_err=1, no output, and all outputs are 0 during and immediately after reset.
REQ-039 With PHV_ALIGN_STATS_EN defined, 20 pairs, 2 overflows and 3 orphans -> pair_cnt=20, drop_phv_cnt=2, drop_act_cnt=3; a forced 0xFFFF holds when incremented.
